// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C temperature-sensor target and its line synchronizer.
// Latency: none (types, constants and a pure helper function only).
// Backpressure: not applicable.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_TX_BYTE   = 3'd3,
    ST_RX_ACK    = 3'd4,
    ST_WAIT_STOP = 3'd5
  } state_t;

  localparam logic [6:0] TEMP_SENSOR_ADDR = 7'h4B;
  localparam int         SYNC_STAGES      = 2;

  // Address byte as it appears on the wire for a read (R/W = 1).
  function automatic logic [7:0] read_addr_byte(input logic [6:0] addr);
    return {addr, 1'b1};
  endfunction

endpackage

// File: rtl/i2c_temp_target_if.sv
// Bus-side bundle of the temperature target: raw SCL/SDA, open-drain SDA pull, sample word, status.
// Latency: none (wires only).
// Backpressure: none; I2C clock stretching is not used, the master owns SCL timing.
//
// Signals:
//   scl_in, sda_in  raw bus lines (asynchronous to the target clock)
//   sda_drive_low   1 = target pulls SDA low, 0 = released
//   temp_word       {MSB, LSB} temperature, sampled at address acknowledge
//   addr_match      one-cycle pulse on an acknowledged read address
//   read_done       one-cycle pulse when the master NACKs a data byte
//   busy            high from START until STOP
interface i2c_temp_target_if;
  logic        scl_in;
  logic        sda_in;
  logic        sda_drive_low;
  logic [15:0] temp_word;
  logic        addr_match;
  logic        read_done;
  logic        busy;

  modport slave (
    input  scl_in, sda_in, temp_word,
    output sda_drive_low, addr_match, read_done, busy
  );

  modport master (
    output scl_in, sda_in, temp_word,
    input  sda_drive_low, addr_match, read_done, busy
  );
endinterface

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizers plus edge, START and STOP detection for any clocked I2C agent.
// Latency: bus event to registered strobe is SYNC_STAGES + 1 clk cycles.
// Backpressure: none; strobes are single-cycle and must be consumed when presented.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   i_scl, i_sda    raw bus lines
//   o_scl_rise/o_scl_fall  one-cycle SCL edge strobes
//   o_start_det/o_stop_det one-cycle START / STOP strobes
//   o_sda_s         synced SDA aligned with the strobes
module i2c_line_sync
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start_det,
  output logic o_stop_det,
  output logic o_sda_s
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_prev;
  logic                   r_sda_prev;
  logic                   r_scl_rise;
  logic                   r_scl_fall;
  logic                   r_start_det;
  logic                   r_stop_det;
  logic                   w_scl_s;
  logic                   w_sda_s;

  assign w_scl_s = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_s = r_sda_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      // Idle bus is high on both lines; resetting to 1 avoids spurious edges.
      r_scl_sync  <= '1;
      r_sda_sync  <= '1;
      r_scl_prev  <= 1'b1;
      r_sda_prev  <= 1'b1;
      r_scl_rise  <= 1'b0;
      r_scl_fall  <= 1'b0;
      r_start_det <= 1'b0;
      r_stop_det  <= 1'b0;
    end else begin
      r_scl_sync  <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync  <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_prev  <= w_scl_s;
      r_sda_prev  <= w_sda_s;
      r_scl_rise  <= w_scl_s & ~r_scl_prev;
      r_scl_fall  <= ~w_scl_s & r_scl_prev;
      // SCL must be high in both samples so an SDA change racing an SCL edge is not a condition.
      r_start_det <= w_scl_s & r_scl_prev & r_sda_prev & ~w_sda_s;
      r_stop_det  <= w_scl_s & r_scl_prev & ~r_sda_prev & w_sda_s;
    end
  end

  assign o_scl_rise  = r_scl_rise;
  assign o_scl_fall  = r_scl_fall;
  assign o_start_det = r_start_det;
  assign o_stop_det  = r_stop_det;
  // r_sda_prev is registered on the same edge as the strobes, so it is the SDA seen at that edge.
  assign o_sda_s     = r_sda_prev;

endmodule

// File: rtl/i2c_temp_target.sv
// I2C read-only target at TEMP_SENSOR_ADDR serving a latched 16-bit temperature word, MSB first.
// Latency: SDA updates one cycle after a registered SCL fall strobe (3-4 clk after SCL falls).
// Backpressure: none; the master paces the transfer and ends it with NACK then STOP.
//
// Ports:
//   clk_200kHz  system clock (the only clock)
//   reset       synchronous active-high reset
//   bus         slave side of i2c_temp_target_if (bus lines, temp_word, status pulses)
module i2c_temp_target
  import i2c_pkg::*;
(
  input  logic                     clk_200kHz,
  input  logic                     reset,
  i2c_temp_target_if.slave         bus
);

  logic        w_scl_rise;
  logic        w_scl_fall;
  logic        w_start_det;
  logic        w_stop_det;
  logic        w_sda_s;
  logic [7:0]  w_cur_byte;
  logic [7:0]  w_next_byte;

  state_t      r_state;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic        r_addr_full;
  logic [15:0] r_tx_word;
  logic        r_byte_sel;
  logic        r_ack_seen;
  logic        r_sda_low;
  logic        r_addr_match;
  logic        r_read_done;
  logic        r_busy;

  i2c_line_sync u_line_sync (
    .clk         (clk_200kHz),
    .rst         (reset),
    .i_scl       (bus.scl_in),
    .i_sda       (bus.sda_in),
    .o_scl_rise  (w_scl_rise),
    .o_scl_fall  (w_scl_fall),
    .o_start_det (w_start_det),
    .o_stop_det  (w_stop_det),
    .o_sda_s     (w_sda_s)
  );

  assign w_cur_byte  = r_byte_sel ? r_tx_word[7:0]  : r_tx_word[15:8];
  // Byte sent after an ACK: the other half of the latched word (MSB follows LSB again).
  assign w_next_byte = r_byte_sel ? r_tx_word[15:8] : r_tx_word[7:0];

  always_ff @(posedge clk_200kHz) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= 3'd7;
      r_shift      <= 8'h00;
      r_addr_full  <= 1'b0;
      r_tx_word    <= 16'h0000;
      r_byte_sel   <= 1'b0;
      r_ack_seen   <= 1'b0;
      r_sda_low    <= 1'b0;
      r_addr_match <= 1'b0;
      r_read_done  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_addr_match <= 1'b0;
      r_read_done  <= 1'b0;

      if (r_state != ST_IDLE && w_stop_det) begin
        r_state   <= ST_IDLE;
        r_sda_low <= 1'b0;
        r_busy    <= 1'b0;
      end else if (w_start_det) begin
        // Covers both a fresh START from IDLE and a repeated START mid-transfer.
        r_state     <= ST_ADDR;
        r_bit_cnt   <= 3'd7;
        r_addr_full <= 1'b0;
        r_sda_low   <= 1'b0;
        r_busy      <= 1'b1;
      end else begin
        case (r_state)
          ST_ADDR: begin
            if (w_scl_rise) begin
              r_shift <= {r_shift[6:0], w_sda_s};
              if (r_bit_cnt == 3'd0) r_addr_full <= 1'b1;
              else                   r_bit_cnt   <= r_bit_cnt - 3'd1;
            end else if (w_scl_fall && r_addr_full) begin
              // The SCL fall right after START has r_addr_full clear and is ignored here.
              if (r_shift == read_addr_byte(TEMP_SENSOR_ADDR)) begin
                r_state      <= ST_ADDR_ACK;
                r_sda_low    <= 1'b1;
                r_tx_word    <= bus.temp_word;
                r_byte_sel   <= 1'b0;
                r_addr_match <= 1'b1;
              end else begin
                r_state <= ST_WAIT_STOP;
              end
            end
          end

          ST_ADDR_ACK: begin
            if (w_scl_fall) begin
              r_state   <= ST_TX_BYTE;
              r_bit_cnt <= 3'd7;
              r_sda_low <= ~r_tx_word[15];
            end
          end

          ST_TX_BYTE: begin
            if (w_scl_fall) begin
              if (r_bit_cnt == 3'd0) begin
                r_state    <= ST_RX_ACK;
                r_sda_low  <= 1'b0;
                r_ack_seen <= 1'b0;
              end else begin
                r_bit_cnt <= r_bit_cnt - 3'd1;
                r_sda_low <= ~w_cur_byte[r_bit_cnt - 3'd1];
              end
            end
          end

          ST_RX_ACK: begin
            if (w_scl_rise) begin
              if (w_sda_s) begin
                r_read_done <= 1'b1;
                r_state     <= ST_WAIT_STOP;
              end else begin
                r_ack_seen <= 1'b1;
              end
            end else if (w_scl_fall && r_ack_seen) begin
              r_byte_sel <= ~r_byte_sel;
              r_state    <= ST_TX_BYTE;
              r_bit_cnt  <= 3'd7;
              r_sda_low  <= ~w_next_byte[7];
            end
          end

          default: begin
            // IDLE and WAIT_STOP only leave on START/STOP, handled above.
          end
        endcase
      end
    end
  end

  assign bus.sda_drive_low = r_sda_low;
  assign bus.addr_match    = r_addr_match;
  assign bus.read_done     = r_read_done;
  assign bus.busy          = r_busy;

endmodule

// File: tb/tb_i2c_temp_target.sv
// Bench for i2c_temp_target: a bit-banged I2C master with an open-drain bus model.
// Expected events and probe values are queued by the stimulus; a monitor compares them.
module tb_i2c_temp_target;

  typedef enum logic [1:0] {EV_AM, EV_RD, EV_ACK, EV_BYTE} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] dat;
  } ev_t;

  typedef enum logic [2:0] {PR_SDA, PR_BUSY, PR_OUTS, PR_DRV, PR_CLR, PR_QEMPTY} pr_t;
  typedef struct {
    pr_t         id;
    logic [31:0] exp;
  } pr_req_t;

  logic        clk_200kHz = 1'b0;
  logic        reset      = 1'b1;
  logic        scl_m      = 1'b1;
  logic        sda_m      = 1'b1;
  logic [15:0] temp       = 16'h0C80;

  logic        obs_vld    = 1'b0;
  ev_kind_t    obs_kind   = EV_BYTE;
  logic [7:0]  obs_dat    = 8'h00;
  logic        probe_vld  = 1'b0;

  ev_t         exp_q[$];
  pr_req_t     pr_q[$];

  int          n_vec     = 0;
  int          n_err     = 0;
  int          drive_cnt = 0;
  logic        prev_am   = 1'b0;
  logic        prev_rd   = 1'b0;

  i2c_temp_target_if bus_if ();

  // Open-drain wired-AND of master and target.
  assign bus_if.scl_in    = scl_m;
  assign bus_if.sda_in    = sda_m & ~bus_if.sda_drive_low;
  assign bus_if.temp_word = temp;

  i2c_temp_target dut (
    .clk_200kHz (clk_200kHz),
    .reset      (reset),
    .bus        (bus_if)
  );

  always #5 clk_200kHz = ~clk_200kHz;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- comparison helpers (used only by the monitor) ----------------
  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic sb_pop(input ev_kind_t k, input logic [7:0] d);
    ev_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL sb_unexpected: got %s %02h, required no event", k.name(), d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== k || e.dat !== d) begin
        n_err++;
        $display("FAIL sb_event: got %s %02h, required %s %02h", k.name(), d, e.kind.name(), e.dat);
      end
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk_200kHz) begin
    pr_req_t p;
    if (bus_if.sda_drive_low) drive_cnt++;
    if (bus_if.addr_match) begin
      cmp("addr_match_width", {31'd0, prev_am}, 32'd0);
      sb_pop(EV_AM, 8'h00);
    end
    if (bus_if.read_done) begin
      cmp("read_done_width", {31'd0, prev_rd}, 32'd0);
      sb_pop(EV_RD, 8'h00);
    end
    if (bus_if.addr_match || bus_if.read_done)
      cmp("pulse_exclusive", {31'd0, bus_if.addr_match & bus_if.read_done}, 32'd0);
    prev_am = bus_if.addr_match;
    prev_rd = bus_if.read_done;
    if (obs_vld) sb_pop(obs_kind, obs_dat);
    if (probe_vld && pr_q.size() != 0) begin
      p = pr_q.pop_front();
      case (p.id)
        PR_SDA:    cmp("sda_drive_low", {31'd0, bus_if.sda_drive_low}, p.exp);
        PR_BUSY:   cmp("busy", {31'd0, bus_if.busy}, p.exp);
        PR_OUTS:   cmp("outputs{sda,am,rd,busy}",
                       {28'd0, bus_if.sda_drive_low, bus_if.addr_match, bus_if.read_done, bus_if.busy},
                       p.exp);
        PR_DRV:    cmp("sda_low_cycles_in_frame", drive_cnt, p.exp);
        PR_QEMPTY: cmp("pending_expected_events", exp_q.size(), p.exp);
        default:   drive_cnt = 0;
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk_200kHz);
    #1;
  endtask

  task automatic expect_ev(input ev_kind_t k, input logic [7:0] d);
    exp_q.push_back('{k, d});
  endtask

  task automatic probe(input pr_t id, input logic [31:0] e);
    pr_q.push_back('{id, e});
    probe_vld = 1'b1;
    cyc(1);
    probe_vld = 1'b0;
  endtask

  task automatic obs(input ev_kind_t k, input logic [7:0] d);
    obs_kind = k;
    obs_dat  = d;
    obs_vld  = 1'b1;
    cyc(1);
    obs_vld  = 1'b0;
  endtask

  task automatic m_start();
    sda_m = 1'b1; scl_m = 1'b1; cyc(10);
    sda_m = 1'b0; cyc(10);
    scl_m = 1'b0;
  endtask

  task automatic m_rstart();
    cyc(2); sda_m = 1'b1; cyc(8);
    scl_m = 1'b1; cyc(5);
    sda_m = 1'b0; cyc(5);
    scl_m = 1'b0;
  endtask

  task automatic m_stop();
    cyc(2); sda_m = 1'b0; cyc(8);
    scl_m = 1'b1; cyc(5);
    sda_m = 1'b1; cyc(10);
  endtask

  task automatic m_wbit(input logic b);
    cyc(2); sda_m = b; cyc(8);
    scl_m = 1'b1; cyc(10);
    scl_m = 1'b0;
  endtask

  task automatic m_rbit(output logic b);
    cyc(2); sda_m = 1'b1; cyc(8);
    scl_m = 1'b1; cyc(5);
    b = bus_if.sda_in; cyc(5);
    scl_m = 1'b0;
  endtask

  task automatic m_wbyte(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) m_wbit(d[i]);
  endtask

  task automatic m_addr(input logic [7:0] a);
    logic b;
    m_wbyte(a);
    m_rbit(b);
    obs(EV_ACK, {7'd0, b});
  endtask

  // ack=1: master ACKs the byte; chg_at>=0 changes temp_word before that bit.
  task automatic m_rbyte(input logic ack, input int chg_at, input logic [15:0] chg_val);
    logic [7:0] d;
    logic       b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (i == chg_at) temp = chg_val;
      m_rbit(b);
      d = {d[6:0], b};
    end
    obs(EV_BYTE, d);
    m_wbit(~ack);
  endtask

  // ---------------- directed vectors ----------------
  initial begin
    reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1; temp = 16'h0C80;
    cyc(5);
    probe(PR_OUTS, 32'h0);
    reset = 1'b0;
    cyc(5);
    probe(PR_OUTS, 32'h0);

    // 1: read 0x97, ACK MSB, NACK LSB.
    expect_ev(EV_AM, 8'h00); expect_ev(EV_ACK, 8'h00);
    expect_ev(EV_BYTE, 8'h0C); expect_ev(EV_BYTE, 8'h80); expect_ev(EV_RD, 8'h00);
    m_start();
    probe(PR_BUSY, 32'h1);
    m_addr(8'h97);
    m_rbyte(1'b1, -1, 16'h0);
    m_rbyte(1'b0, -1, 16'h0);
    m_stop();
    probe(PR_OUTS, 32'h0);

    // 2: read from 0x48: never acknowledged, SDA never pulled.
    probe(PR_CLR, 32'h0);
    expect_ev(EV_ACK, 8'h01);
    m_start();
    m_addr(8'h91);
    m_wbyte(8'hFF);
    m_wbit(1'b1);
    probe(PR_BUSY, 32'h1);
    m_stop();
    probe(PR_DRV, 32'h0);
    probe(PR_OUTS, 32'h0);

    // 3: write to 0x4B: NACKed, no pulses.
    probe(PR_CLR, 32'h0);
    expect_ev(EV_ACK, 8'h01);
    m_start();
    m_addr(8'h96);
    m_wbyte(8'h55);
    m_wbit(1'b1);
    m_stop();
    probe(PR_DRV, 32'h0);
    probe(PR_OUTS, 32'h0);

    // 4: temp_word changes during the MSB; latched word still returned.
    temp = 16'h0C80;
    expect_ev(EV_AM, 8'h00); expect_ev(EV_ACK, 8'h00);
    expect_ev(EV_BYTE, 8'h0C); expect_ev(EV_BYTE, 8'h80); expect_ev(EV_RD, 8'h00);
    m_start();
    m_addr(8'h97);
    m_rbyte(1'b1, 3, 16'h1900);
    m_rbyte(1'b0, -1, 16'h0);
    m_stop();
    probe(PR_OUTS, 32'h0);

    // 5: ACK LSB, third byte repeats the latched MSB.
    temp = 16'h0C80;
    expect_ev(EV_AM, 8'h00); expect_ev(EV_ACK, 8'h00);
    expect_ev(EV_BYTE, 8'h0C); expect_ev(EV_BYTE, 8'h80);
    expect_ev(EV_BYTE, 8'h0C); expect_ev(EV_RD, 8'h00);
    m_start();
    m_addr(8'h97);
    m_rbyte(1'b1, 2, 16'h1900);
    m_rbyte(1'b1, -1, 16'h0);
    m_rbyte(1'b0, -1, 16'h0);
    m_stop();
    probe(PR_OUTS, 32'h0);

    // 6: reset while the target pulls SDA low for MSB bit 7 (0x0C -> bit7 = 0).
    temp = 16'h0C80;
    expect_ev(EV_AM, 8'h00); expect_ev(EV_ACK, 8'h00);
    m_start();
    m_addr(8'h97);
    cyc(5);
    probe(PR_SDA, 32'h1);
    reset = 1'b1;
    cyc(1);
    probe(PR_SDA, 32'h0);
    probe(PR_OUTS, 32'h0);
    scl_m = 1'b1; sda_m = 1'b1;
    cyc(5);
    reset = 1'b0;
    cyc(5);
    probe(PR_OUTS, 32'h0);

    // 7: NACK MSB, repeated START, then a full second read of a new word.
    temp = 16'h0C80;
    expect_ev(EV_AM, 8'h00); expect_ev(EV_ACK, 8'h00);
    expect_ev(EV_BYTE, 8'h0C); expect_ev(EV_RD, 8'h00);
    m_start();
    m_addr(8'h97);
    m_rbyte(1'b0, -1, 16'h0);
    m_rstart();
    probe(PR_BUSY, 32'h1);
    temp = 16'h1900;
    expect_ev(EV_AM, 8'h00); expect_ev(EV_ACK, 8'h00);
    expect_ev(EV_BYTE, 8'h19); expect_ev(EV_BYTE, 8'h00); expect_ev(EV_RD, 8'h00);
    m_addr(8'h97);
    m_rbyte(1'b1, -1, 16'h0);
    m_rbyte(1'b0, -1, 16'h0);
    m_stop();
    probe(PR_OUTS, 32'h0);

    cyc(5);
    probe(PR_QEMPTY, 32'h0);
    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_temp_target.md
# i2c_temp_target

I2C target (slave) that emulates the on-board temperature sensor and answers read transactions from the team's I2C temperature master. Sits on the same SDA/SCL pair as the master, in simulation benches or as a stand-in sensor on boards without one. Serves a 16-bit temperature word as MSB then LSB. The word is latched at the address match so a read never returns mixed samples.

## Interface
- ADDR, 7'h4B — 7-bit target address; only reads (R/W=1) to this address are acknowledged.
- clk_200kHz  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- scl_in  input  1  raw SCL from bus (asynchronous to clk_200kHz).
- sda_in  input  1  raw SDA from bus (asynchronous).
- sda_drive_low  output  1  1 = pull SDA low; 0 = release (open-drain; top level maps to 1'b0/1'bz).
- temp_word  input  16  current temperature, {MSB byte, LSB byte}; sampled at address ACK.
- addr_match  output  1  one-cycle pulse when a matching read address is acknowledged.
- read_done  output  1  one-cycle pulse when the master NACKs a data byte (transfer complete).
- busy  output  1  high from START detection until STOP or return to IDLE.

## Operation
- Both bus lines pass through 2-flop synchronizers. Edge detection then produces scl_rise, scl_fall, start_det (SDA falls while synced SCL high) and stop_det (SDA rises while synced SCL high).
- States: IDLE, ADDR, ADDR_ACK, TX_BYTE, RX_ACK, WAIT_STOP.
- IDLE: on start_det -> ADDR, bit_cnt=7, busy=1.
- ADDR: shift synced SDA into shift_reg on each scl_rise. After the 8th bit, on the next scl_fall:
  - shift_reg == {ADDR,1'b1} -> ADDR_ACK, sda_drive_low=1, latch temp_word into tx_word, byte_sel=0, pulse addr_match.
  - Else -> WAIT_STOP, SDA released. This covers address mismatch and all write requests.
- ADDR_ACK: on scl_fall ending the ACK clock -> TX_BYTE, bit_cnt=7, drive first data bit.
- TX_BYTE: sda_drive_low = ~bit of the selected byte (byte_sel=0: tx_word[15:8], 1: tx_word[7:0]), updated on scl_fall. After bit 0, the next scl_fall releases SDA -> RX_ACK.
- RX_ACK: sample SDA on scl_rise.
  - SDA=0 (ACK): on the following scl_fall toggle byte_sel and go to TX_BYTE. MSB follows LSB again; tx_word is not re-latched.
  - SDA=1 (NACK): pulse read_done -> WAIT_STOP.
- WAIT_STOP: SDA released; ignore SCL.
- Priority, from any non-IDLE state: stop_det -> IDLE (SDA released, busy=0); start_det (repeated START) -> ADDR. Both take priority over all other transitions in the same cycle.
- reset has priority over everything. The target must release SDA within one cycle of reset asserted, including mid-byte.

## Timing
- Reset values: sda_drive_low=0, addr_match=0, read_done=0, busy=0, state IDLE, synchronizer flops 1 (idle bus).
- Bus event to internal strobe: 3 clk_200kHz cycles (2 sync + 1 edge register).
- sda_drive_low changes only in the cycle after scl_fall is registered, i.e. 3–4 cycles after SCL falls. With a 20-cycle SCL period (10 low), data is stable at least 6 cycles before SCL rises. sda_drive_low never changes while synced SCL is high.
- SDA samples use the synced SDA of the same cycle as scl_rise (equal sync depth on both lines).
- addr_match and read_done are exactly one cycle wide; they never assert together.
- temp_word is sampled in the same cycle addr_match is high; later changes do not affect the ongoing transfer.

## Structure
- Shared package i2c_pkg:
  - state enum (6 states, 3 bits)
  - localparam TEMP_SENSOR_ADDR = 7'h4B
  - localparam SYNC_STAGES = 2
- Sub-module i2c_line_sync:
  - synchronizers plus edge/condition detection for SCL/SDA
  - outputs scl_rise, scl_fall, start_det, stop_det, sda_s
  - reusable by a future synchronizing master
- Top FSM, shift register, bit counter and byte_sel live in i2c_temp_target.

## Test plan
- Read at 0x4B, R=1 (0x97), temp_word=16'h0C80, master ACKs MSB, NACKs LSB -> ADDR ACK low; bytes 0x0C, 0x80 on SDA; one addr_match, one read_done; SDA released; busy=0 after STOP.
- Address 0x48 read (0x91) -> SDA never driven low during the frame; no addr_match; WAIT_STOP until STOP; busy falls.
- Write to 0x4B (0x96) -> ACK bit released (NACK); no pulses; returns to IDLE on STOP.
- temp_word changes 16'h0C80 -> 16'h1900 during MSB transfer -> master still receives 0x0C, 0x80.
- Master ACKs LSB, then NACKs the next byte -> third byte is 0x0C (MSB repeat); read_done after the third byte.
- reset asserted mid-MSB while driving low -> sda_drive_low=0 the next cycle; all outputs at reset values. Repeated START mid-read -> back to ADDR; the next 0x97 frame completes normally.
